// File: rtl/pio_cfg_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pio_cfg_bank
//
// Double-buffered Avalon-MM output PIO bank for accelerator configuration.
// The HPS writes NUM_CH shadow registers and then commits. On a commit, all
// shadow registers move into the active registers in the same cycle. The
// active registers drive out_port and are offered to the accelerator with a
// cfg_valid/cfg_ready handshake.
//
// Address map (word addresses):
//   0..NUM_CH-1 : shadow channel k (R/W, byte-lane writes)
//   NUM_CH      : CTRL (write) / STATUS (read)
//   others      : writes ignored, reads return 0
//
// CTRL write bits (ignored unless byteenable[0] is set):
//   [0] COMMIT  [1] CLR_OVF  [2] CLR_DONE  [3] IRQ_MASK
// STATUS read bits:
//   [0] cfg_valid  [1] overflow  [2] done_sticky  [3] irq_mask
//
// Optional feature macro: PIO_CFG_DONE_IRQ_EN
//   Defined   : the done level is registered, its rising edges set
//               done_sticky, and irq = done_sticky & irq_mask (registered).
//   Undefined : done is ignored, done_sticky reads 0 and irq is tied to 0.
//
// Ports:
//   clk, reset_n    system clock and asynchronous active-low reset
//   address         Avalon word address
//   chipselect      slave select
//   write_n         active-low write strobe
//   byteenable      write byte lanes
//   writedata       write data
//   readdata        zero wait-state read data, combinational from address
//   out_port        active registers, channel k at [k*DATA_W +: DATA_W]
//   cfg_valid       active configuration pending for the accelerator
//   cfg_ready       accelerator accepts the configuration
//   done            accelerator completion level
//   irq             interrupt request
// ---------------------------------------------------------------------------
module pio_cfg_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     cfg_valid,
  input  logic                     cfg_ready,
  input  logic                     done,
  output logic                     irq
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] active [NUM_CH];

  logic wr;
  logic ctrl_wr;
  logic commit;
  logic clr_ovf;
  logic accept;
  logic commit_ok;
  logic commit_rej;
  logic overflow;
  logic irq_mask;
  logic done_sticky;
  logic [DATA_W-1:0] status;

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr & (address == CTRL_ADDR) & byteenable[0];
  assign commit  = ctrl_wr & writedata[0];
  assign clr_ovf = ctrl_wr & writedata[1];
  assign accept  = cfg_valid & cfg_ready;

  // A commit is taken when nothing is pending, or when the pending
  // configuration is being accepted in the same cycle (back-to-back update).
  assign commit_ok  = commit & (~cfg_valid | accept);
  assign commit_rej = commit & cfg_valid & ~cfg_ready;

  // Shadow registers: per-byte-lane writes from the Avalon side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else if (wr) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (address == ADDR_W'(k)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (byteenable[b]) shadow[k][b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Active registers: whole bank copied atomically on an accepted commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) active[k] <= '0;
    end else if (commit_ok) begin
      for (int k = 0; k < NUM_CH; k++) active[k] <= shadow[k];
    end
  end

  // Handshake, sticky overflow and interrupt mask. A rejected commit beats
  // a CLR_OVF carried in the same write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_valid <= 1'b0;
      overflow  <= 1'b0;
      irq_mask  <= 1'b0;
    end else begin
      if (commit_ok)   cfg_valid <= 1'b1;
      else if (accept) cfg_valid <= 1'b0;

      if (commit_rej)   overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (ctrl_wr) irq_mask <= writedata[3];
    end
  end

`ifdef PIO_CFG_DONE_IRQ_EN
  logic done_q;
  logic done_prev;
  logic primed;
  logic done_rise;
  logic clr_done;
  logic sticky_next;
  logic mask_next;

  assign clr_done    = ctrl_wr & writedata[2];
  assign done_rise   = done_q & ~done_prev;
  assign sticky_next = done_rise | (done_sticky & ~clr_done);
  assign mask_next   = ctrl_wr ? writedata[3] : irq_mask;

  // On the first edge after reset, done_prev is loaded with the same sample
  // as done_q, so a level already high during reset is not seen as an edge.
  // irq is registered from the next-state values so it tracks
  // done_sticky & irq_mask without an extra cycle of lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q      <= 1'b0;
      done_prev   <= 1'b0;
      primed      <= 1'b0;
      done_sticky <= 1'b0;
      irq         <= 1'b0;
    end else begin
      done_q      <= done;
      done_prev   <= primed ? done_q : done;
      primed      <= 1'b1;
      done_sticky <= sticky_next;
      irq         <= sticky_next & mask_next;
    end
  end
`else
  logic unused_done;

  assign unused_done = done;
  assign done_sticky = 1'b0;
  assign irq         = 1'b0;
`endif

  assign status = DATA_W'({irq_mask, done_sticky, overflow, cfg_valid});

  // Read mux: shadow values for channel addresses, status at CTRL_ADDR.
  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (address == ADDR_W'(k)) readdata = shadow[k];
    end
    if (address == CTRL_ADDR) readdata = status;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = active[g];
    end
  endgenerate

endmodule

// File: tb/tb_pio_cfg_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pio_cfg_bank
//
// Self-checking bench for pio_cfg_bank (NUM_CH=4, DATA_W=32, ADDR_W=4).
// A table of directed vectors covers register access and the commit
// handshake; hand-written sequences cover done/irq and asynchronous reset.
// Expectations for done/irq follow PIO_CFG_DONE_IRQ_EN.
// ---------------------------------------------------------------------------
module tb_pio_cfg_bank;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  localparam int OP_NOP = 0;
  localparam int OP_WR  = 1;
  localparam int OP_RD  = 2;

  logic                     clk;
  logic                     reset_n;
  logic [ADDR_W-1:0]        address;
  logic                     chipselect;
  logic                     write_n;
  logic [DATA_W/8-1:0]      byteenable;
  logic [DATA_W-1:0]        writedata;
  logic [DATA_W-1:0]        readdata;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic                     done;
  logic                     irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           op;
    logic [3:0]   addr;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         ready;
    logic [31:0]  exp_rd;
    logic         exp_valid;
    logic [127:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  pio_cfg_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .done       (done),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    cfg_ready  = 1'b0;
  endtask

  // One table row: drive at the falling edge, check readdata before the
  // rising edge, then check cfg_valid/out_port just after it.
  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    address    = v.addr;
    byteenable = v.be;
    writedata  = v.wdata;
    cfg_ready  = v.ready;
    chipselect = (v.op != OP_NOP);
    write_n    = (v.op != OP_WR);
    #1;
    if (v.op == OP_RD)
      check_output($sformatf("vec%0d_readdata", idx), 128'(readdata), 128'(v.exp_rd));
    @(posedge clk);
    #1;
    bus_idle();
    check_output($sformatf("vec%0d_cfg_valid", idx), 128'(cfg_valid), 128'(v.exp_valid));
    check_output($sformatf("vec%0d_out_port", idx), out_port, v.exp_out);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    byteenable = be;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check_output(name, 128'(readdata), 128'(exp));
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  localparam logic [127:0] O0 = 128'h0;
  localparam logic [127:0] O1 = 128'h00000000_00000000_00000020_00000010;
  localparam logic [127:0] O2 = 128'h00000000_00000000_00000020_000000AA;
  localparam logic [127:0] O3 = 128'h00000000_FF34FF78_00000020_000000AA;

  initial begin
    bit irq_seen;

    reset_n = 1'b0;
    done    = 1'b0;
    bus_idle();

    //           op     addr   be     wdata         rdy   exp_rd        v     out
    vecs.push_back('{OP_RD,  4'd0,  4'hF, 32'h0,        1'b0, 32'h0,        1'b0, O0});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h0,        1'b0, O0});
    vecs.push_back('{OP_WR,  4'd0,  4'hF, 32'h10,       1'b0, 32'h0,        1'b0, O0});
    vecs.push_back('{OP_WR,  4'd1,  4'hF, 32'h20,       1'b0, 32'h0,        1'b0, O0});
    vecs.push_back('{OP_RD,  4'd1,  4'hF, 32'h0,        1'b0, 32'h20,       1'b0, O0});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h1,        1'b0, 32'h0,        1'b1, O1});
    vecs.push_back('{OP_NOP, 4'd0,  4'h0, 32'h0,        1'b1, 32'h0,        1'b0, O1});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h1,        1'b0, 32'h0,        1'b1, O1});
    vecs.push_back('{OP_WR,  4'd0,  4'hF, 32'hAA,       1'b0, 32'h0,        1'b1, O1});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h1,        1'b0, 32'h0,        1'b1, O1});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h3,        1'b1, O1});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h2,        1'b0, 32'h0,        1'b1, O1});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h1,        1'b1, O1});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h1,        1'b1, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h1,        1'b1, O2});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h3,        1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h3,        1'b1, O2});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h2,        1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd0,  4'hF, 32'h0,        1'b0, 32'hAA,       1'b1, O2});
    vecs.push_back('{OP_WR,  4'd2,  4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_WR,  4'd2,  4'h5, 32'h12345678, 1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd2,  4'hF, 32'h0,        1'b0, 32'hFF34FF78, 1'b1, O2});
    vecs.push_back('{OP_RD,  4'd5,  4'hF, 32'h0,        1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_WR,  4'd5,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd5,  4'hF, 32'h0,        1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_RD,  4'd15, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, O2});
    vecs.push_back('{OP_NOP, 4'd0,  4'h0, 32'h0,        1'b1, 32'h0,        1'b0, O2});
    vecs.push_back('{OP_WR,  4'd4,  4'hE, 32'h1,        1'b0, 32'h0,        1'b0, O2});
    vecs.push_back('{OP_NOP, 4'd0,  4'h0, 32'h0,        1'b1, 32'h0,        1'b0, O2});
    vecs.push_back('{OP_WR,  4'd4,  4'hF, 32'h8,        1'b0, 32'h0,        1'b0, O2});
    vecs.push_back('{OP_RD,  4'd4,  4'hF, 32'h0,        1'b0, 32'h8,        1'b0, O2});
    vecs.push_back('{OP_RD,  4'd3,  4'hF, 32'h0,        1'b0, 32'h0,        1'b0, O2});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_cfg_valid", 128'(cfg_valid), 128'(1'b0));
    check_output("reset_out_port", out_port, O0);
    check_output("reset_irq", 128'(irq), 128'(1'b0));

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // done / irq with irq_mask already set by the table
    check_output("irq_before_done", 128'(irq), 128'(1'b0));
    @(negedge clk);
    done = 1'b1;
`ifdef PIO_CFG_DONE_IRQ_EN
    irq_seen = 1'b0;
    for (int i = 0; i < 3 && !irq_seen; i++) begin
      @(posedge clk);
      #1;
      if (irq) irq_seen = 1'b1;
    end
    check_output("irq_rise_within_3", 128'(irq_seen), 128'(1'b1));
    do_read(4'd4, 32'hC, "status_done_sticky");
    do_write(4'd4, 4'hF, 32'hC);
    check_output("irq_after_clr_done", 128'(irq), 128'(1'b0));
    @(posedge clk);
    #1;
    check_output("irq_stays_low", 128'(irq), 128'(1'b0));
    do_read(4'd4, 32'h8, "status_after_clr_done");
`else
    irq_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (irq) irq_seen = 1'b1;
    end
    check_output("irq_tied_low", 128'(irq_seen), 128'(1'b0));
    do_read(4'd4, 32'h8, "status_no_done");
`endif

    // Asynchronous reset during a pending handshake, with done held high
    do_write(4'd4, 4'hF, 32'h1);
    check_output("commit_before_reset_valid", 128'(cfg_valid), 128'(1'b1));
    check_output("commit_before_reset_out", out_port, O3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_valid", 128'(cfg_valid), 128'(1'b0));
    check_output("async_reset_out", out_port, O0);
    check_output("async_reset_irq", 128'(irq), 128'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("no_done_edge_from_reset_irq", 128'(irq), 128'(1'b0));
    do_read(4'd4, 32'h0, "status_after_reset");
    do_read(4'd2, 32'h0, "shadow_after_reset");
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
